// File: rtl/lcd_hd44780_responder.sv
// Responder-side model of a 16x2 HD44780-style character LCD.
// Decodes the controller's E/RS/RW/DATA strobes, executes the command subset
// the controller issues, tracks the busy time and keeps a 2x16 character
// buffer that can be read back on a side port.
module lcd_hd44780_responder #(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000,
  parameter int unsigned CNT_W        = 17
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic       wr_strobe,
  output logic [4:0] wr_idx,
  output logic [7:0] wr_char,
  output logic       busy,
  output logic       display_on,
  output logic       err_busy
);

  typedef enum logic [3:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISPLAY,
    CMD_SHIFT,
    CMD_FUNC,
    CMD_CGRAM,
    CMD_DDRAM
  } cmd_e;

  localparam logic [7:0] BLANK = 8'h20;

  // DDRAM address stepping: the two 40-byte lines form one 80-entry ring.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // strobe capture
  logic             en_q;
  logic             rs_q;
  logic             rw_q;
  logic [7:0]       data_q;

  // architectural state
  logic [6:0]       ac;
  logic             inc_mode;
  logic             cgram_mode;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cells [32];

  // decode results
  logic             fall;
  cmd_e             cmd;
  logic [6:0]       ac_nxt;
  logic             inc_nxt;
  logic             disp_nxt;
  logic             cgram_nxt;
  logic             clear_all;
  logic             buf_we;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             ac_visible;
  logic [4:0]       ac_idx;
  logic [7:0]       ac_cell;

  // Register RS/RW/DATA while E is high so the falling edge sees the last E=1 values
  always_ff @(posedge clock) begin
    if (rst) begin
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      rw_q   <= 1'b0;
      data_q <= '0;
    end else begin
      en_q <= lcd_en;
      if (lcd_en) begin
        rs_q   <= lcd_rs;
        rw_q   <= lcd_rw;
        data_q <= lcd_data_in;
      end
    end
  end

  // Decode the captured transfer and compute next state for the falling-edge cycle
  always_comb begin
    fall       = en_q & ~lcd_en;
    ac_visible = (ac[5:4] == 2'b00);
    ac_idx     = {ac[6], ac[3:0]};
    ac_cell    = cells[ac_idx];

    cmd = CMD_NONE;
    casez (data_q)
      8'b1???????: cmd = CMD_DDRAM;
      8'b01??????: cmd = CMD_CGRAM;
      8'b001?????: cmd = CMD_FUNC;
      8'b0001????: cmd = CMD_SHIFT;
      8'b00001???: cmd = CMD_DISPLAY;
      8'b000001??: cmd = CMD_ENTRY;
      8'b0000001?: cmd = CMD_HOME;
      8'b00000001: cmd = CMD_CLEAR;
      default:     cmd = CMD_NONE;
    endcase

    ac_nxt    = ac;
    inc_nxt   = inc_mode;
    disp_nxt  = display_on;
    cgram_nxt = cgram_mode;
    clear_all = 1'b0;
    buf_we    = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = CNT_W'(BUSY_CYCLES);

    if (fall) begin
      if (!rw_q) begin
        cnt_load = 1'b1;
        if (rs_q) begin
          buf_we = ac_visible & ~cgram_mode;
          ac_nxt = ac_step(ac, inc_mode);
        end else begin
          unique case (cmd)
            CMD_CLEAR: begin
              clear_all = 1'b1;
              ac_nxt    = '0;
              inc_nxt   = 1'b1;
              cgram_nxt = 1'b0;
              cnt_val   = CNT_W'(CLEAR_CYCLES);
            end
            CMD_HOME:    ac_nxt   = '0;
            CMD_ENTRY:   inc_nxt  = data_q[1];
            CMD_DISPLAY: disp_nxt = data_q[2];
            CMD_SHIFT: begin
              if (!data_q[3]) ac_nxt = ac_step(ac, data_q[2]);
            end
            CMD_CGRAM: cgram_nxt = 1'b1;
            CMD_DDRAM: begin
              ac_nxt    = data_q[6:0];
              cgram_nxt = 1'b0;
            end
            default: ;
          endcase
        end
      end else if (rs_q) begin
        ac_nxt = ac_step(ac, inc_mode);
      end
    end
  end

  // Control state, busy counter, sticky error and write-notification outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      ac         <= '0;
      inc_mode   <= 1'b1;
      display_on <= 1'b0;
      cgram_mode <= 1'b0;
      cnt        <= '0;
      err_busy   <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_idx     <= '0;
      wr_char    <= '0;
    end else begin
      ac         <= ac_nxt;
      inc_mode   <= inc_nxt;
      display_on <= disp_nxt;
      cgram_mode <= cgram_nxt;
      wr_strobe  <= buf_we;
      if (buf_we) begin
        wr_idx  <= ac_idx;
        wr_char <= data_q;
      end
      if (cnt_load)  cnt <= cnt_val;
      else if (busy) cnt <= cnt - CNT_W'(1);
      if (fall && busy) err_busy <= 1'b1;
    end
  end

  // Character buffer: blank on reset or clear, otherwise one cell per data write
  always_ff @(posedge clock) begin
    if (rst || clear_all) begin
      for (int unsigned i = 0; i < 32; i++) cells[i] <= BLANK;
    end else if (buf_we) begin
      cells[ac_idx] <= data_q;
    end
  end

  // Side-port read; sampling before the buffer update returns the old value on a collision
  always_ff @(posedge clock) begin
    if (rst) rd_char <= '0;
    else     rd_char <= cells[rd_idx];
  end

  // Busy flag and bus read-back, driven only while the controller reads
  always_comb begin
    busy         = (cnt != '0);
    lcd_data_oe  = lcd_en & lcd_rw;
    lcd_data_out = '0;
    if (lcd_data_oe) begin
      if (lcd_rs) lcd_data_out = ac_visible ? ac_cell : BLANK;
      else        lcd_data_out = {busy, ac};
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder: directed vector table,
// hand-written corner sequences, and randomized transfers against a
// behavioural model of the LCD (ring-addressed DDRAM, deadline-based busy).
module tb_lcd_hd44780_responder;

  localparam int BUSY  = 12;
  localparam int CLEAR = 60;

  logic       clock = 1'b0;
  logic       rst;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] rd_idx;
  logic [7:0] rd_char;
  logic       wr_strobe;
  logic [4:0] wr_idx;
  logic [7:0] wr_char;
  logic       busy;
  logic       display_on;
  logic       err_busy;

  lcd_hd44780_responder #(
    .BUSY_CYCLES (BUSY),
    .CLEAR_CYCLES(CLEAR),
    .CNT_W       (8)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .lcd_en      (lcd_en),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_data_in (lcd_data_in),
    .lcd_data_out(lcd_data_out),
    .lcd_data_oe (lcd_data_oe),
    .rd_idx      (rd_idx),
    .rd_char     (rd_char),
    .wr_strobe   (wr_strobe),
    .wr_idx      (wr_idx),
    .wr_char     (wr_char),
    .busy        (busy),
    .display_on  (display_on),
    .err_busy    (err_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  logic [7:0] m_cells [32];
  int         m_ac;
  bit         m_inc, m_disp, m_cgram, m_err;
  int         m_end;  // first edge count at which the display is idle again

  function automatic bit m_busy();
    return cyc < m_end;
  endfunction

  function automatic bit vis(input int a);
    return (a < 16) || (a >= 64 && a < 80);
  endfunction

  function automatic int cidx(input int a);
    return (a >= 64) ? 16 + (a - 64) : a;
  endfunction

  // Step along the 80-position DDRAM ring; off-ring addresses wrap in 7 bits.
  function automatic int step(input int a, input bit up);
    int p;
    if (a < 'h28) p = a;
    else if (a >= 'h40 && a < 'h68) p = a - 'h40 + 40;
    else return up ? (a + 1) % 128 : (a + 127) % 128;
    p = up ? (p + 1) % 80 : (p + 79) % 80;
    return (p < 40) ? p : p - 40 + 'h40;
  endfunction

  function automatic logic [7:0] m_read(input bit rs);
    if (rs) return vis(m_ac) ? m_cells[cidx(m_ac)] : 8'h20;
    return {m_busy(), 7'(m_ac)};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
    m_ac = 0; m_inc = 1; m_disp = 0; m_cgram = 0; m_err = 0; m_end = 0;
  endtask

  // Apply one transfer to the model; called just after the executing edge.
  task automatic m_exec(input bit rs, input bit rw, input logic [7:0] d,
                        output bit stb, output int sidx, output logic [7:0] sch);
    int hb;
    stb = 0; sidx = 0; sch = 8'h00;
    if (cyc - 1 < m_end) m_err = 1;
    if (rw) begin
      if (rs) m_ac = step(m_ac, m_inc);
    end else if (rs) begin
      if (vis(m_ac) && !m_cgram) begin
        stb = 1; sidx = cidx(m_ac); sch = d; m_cells[sidx] = d;
      end
      m_ac  = step(m_ac, m_inc);
      m_end = cyc + BUSY;
    end else begin
      hb = -1;
      for (int b = 0; b < 8; b++) if (d[b]) hb = b;
      m_end = cyc + BUSY;
      case (hb)
        0: begin
          for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
          m_ac = 0; m_inc = 1; m_cgram = 0; m_end = cyc + CLEAR;
        end
        1: m_ac = 0;
        2: m_inc = d[1];
        3: m_disp = d[2];
        4: if (!d[3]) m_ac = step(m_ac, d[2]);
        6: m_cgram = 1;
        7: begin m_ac = int'(d & 8'h7F); m_cgram = 0; end
        default: ;
      endcase
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    while (m_busy()) tick();
    tick();
  endtask

  // One bus transfer with E high for `hold` clocks; checks the bus read-back
  // while E is high and the write notification/status right after execution.
  task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input int hold,
                      output bit stb, output logic [7:0] rd_first);
    int         sidx;
    logic [7:0] sch;
    rd_first = 8'h00;
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("oe_high", 32'(lcd_data_oe), 32'(rw));
      if (rw) chk("bus_read", 32'(lcd_data_out), 32'(m_read(rs)));
      if (h == 0) rd_first = lcd_data_out;
      tick();
    end
    lcd_en = 1'b0;
    lcd_rs = 1'($urandom); lcd_rw = 1'($urandom); lcd_data_in = 8'($urandom);
    #1;
    chk("oe_low", 32'(lcd_data_oe), 32'(0));
    chk("out_low", 32'(lcd_data_out), 32'(0));
    tick();
    m_exec(rs, rw, d, stb, sidx, sch);
    chk("wr_strobe", 32'(wr_strobe), 32'(stb));
    if (stb) begin
      chk("wr_idx", 32'(wr_idx), 32'(sidx));
      chk("wr_char", 32'(wr_char), 32'(sch));
    end
    chk("busy", 32'(busy), 32'(m_busy()));
    chk("err_busy", 32'(err_busy), 32'(m_err));
    chk("display_on", 32'(display_on), 32'(m_disp));
  endtask

  task automatic check_all(input string nm);
    for (int i = 0; i < 32; i++) begin
      rd_idx = 5'(i);
      tick();
      chk(nm, 32'(rd_char), 32'(m_cells[i]));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rs;
    bit         rw;
    logic [7:0] d;
    bit         stb;
    logic [4:0] idx;
    logic [7:0] ch;
    logic [7:0] rd;
    logic [6:0] ac;
    bit         disp;
  } vec_t;

  vec_t tbl [25];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles required fewer", cyc);
    $fatal(1);
  end

  initial begin
    bit         stb;
    logic [7:0] rdv;
    logic [7:0] old;
    int         n, r, k;
    bit         rs, rw;
    logic [7:0] d;

    //              rs rw d      stb idx ch     rd     ac     disp
    tbl[0]  = '{0, 0, 8'h80, 0, 0,  8'h00, 8'h00, 7'h00, 0};
    tbl[1]  = '{1, 0, 8'h48, 1, 0,  8'h48, 8'h00, 7'h01, 0};
    tbl[2]  = '{1, 0, 8'h49, 1, 1,  8'h49, 8'h00, 7'h02, 0};
    tbl[3]  = '{0, 0, 8'hCF, 0, 0,  8'h00, 8'h00, 7'h4F, 0};
    tbl[4]  = '{1, 0, 8'h41, 1, 31, 8'h41, 8'h00, 7'h50, 0};
    tbl[5]  = '{1, 0, 8'h42, 0, 0,  8'h00, 8'h00, 7'h51, 0};
    tbl[6]  = '{0, 0, 8'h04, 0, 0,  8'h00, 8'h00, 7'h51, 0};
    tbl[7]  = '{0, 0, 8'h80, 0, 0,  8'h00, 8'h00, 7'h00, 0};
    tbl[8]  = '{1, 0, 8'h5A, 1, 0,  8'h5A, 8'h00, 7'h67, 0};
    tbl[9]  = '{0, 0, 8'h06, 0, 0,  8'h00, 8'h00, 7'h67, 0};
    tbl[10] = '{0, 0, 8'h14, 0, 0,  8'h00, 8'h00, 7'h00, 0};
    tbl[11] = '{0, 0, 8'h10, 0, 0,  8'h00, 8'h00, 7'h67, 0};
    tbl[12] = '{0, 0, 8'h18, 0, 0,  8'h00, 8'h00, 7'h67, 0};
    tbl[13] = '{0, 0, 8'hA7, 0, 0,  8'h00, 8'h00, 7'h27, 0};
    tbl[14] = '{1, 0, 8'h33, 0, 0,  8'h00, 8'h00, 7'h40, 0};
    tbl[15] = '{1, 0, 8'h34, 1, 16, 8'h34, 8'h00, 7'h41, 0};
    tbl[16] = '{0, 0, 8'h40, 0, 0,  8'h00, 8'h00, 7'h41, 0};
    tbl[17] = '{1, 0, 8'h55, 0, 0,  8'h00, 8'h00, 7'h42, 0};
    tbl[18] = '{0, 0, 8'h0C, 0, 0,  8'h00, 8'h00, 7'h42, 1};
    tbl[19] = '{0, 0, 8'h28, 0, 0,  8'h00, 8'h00, 7'h42, 1};
    tbl[20] = '{0, 0, 8'h02, 0, 0,  8'h00, 8'h00, 7'h00, 1};
    tbl[21] = '{0, 0, 8'h80, 0, 0,  8'h00, 8'h00, 7'h00, 1};
    tbl[22] = '{1, 1, 8'h00, 0, 0,  8'h00, 8'h5A, 7'h01, 1};
    tbl[23] = '{1, 1, 8'h00, 0, 0,  8'h00, 8'h49, 7'h02, 1};
    tbl[24] = '{0, 1, 8'h00, 0, 0,  8'h00, 8'h02, 7'h02, 1};

    // ---- reset state ----
    rst = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = 8'h00; rd_idx = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err", 32'(err_busy), 32'(0));
    chk("rst_strobe", 32'(wr_strobe), 32'(0));
    chk("rst_oe", 32'(lcd_data_oe), 32'(0));
    chk("rst_out", 32'(lcd_data_out), 32'(0));
    chk("rst_rd_char", 32'(rd_char), 32'(0));
    chk("rst_disp", 32'(display_on), 32'(0));
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 32; i++) begin
      rd_idx = 5'(i);
      tick();
      chk("rst_cell", 32'(rd_char), 32'h20);
    end

    // ---- table-driven directed vectors, AC confirmed by an idle status read ----
    for (int i = 0; i < 25; i++) begin
      xfer(tbl[i].rs, tbl[i].rw, tbl[i].d, 1, stb, rdv);
      chk("tbl_strobe", 32'(wr_strobe), 32'(tbl[i].stb));
      if (tbl[i].stb) begin
        chk("tbl_wr_idx", 32'(wr_idx), 32'(tbl[i].idx));
        chk("tbl_wr_char", 32'(wr_char), 32'(tbl[i].ch));
      end
      if (tbl[i].rw) chk("tbl_read", 32'(rdv), 32'(tbl[i].rd));
      chk("tbl_disp", 32'(display_on), 32'(tbl[i].disp));
      wait_idle();
      xfer(1'b0, 1'b1, 8'h00, 1, stb, rdv);
      chk("tbl_ac", 32'(rdv), 32'({1'b0, tbl[i].ac}));
      chk("tbl_err", 32'(err_busy), 32'(0));
    end
    rd_idx = 5'd1;  tick(); chk("cell1_I", 32'(rd_char), 32'h49);
    rd_idx = 5'd31; tick(); chk("cell31_A", 32'(rd_char), 32'h41);
    rd_idx = 5'd0;  tick(); chk("cell0_Z", 32'(rd_char), 32'h5A);
    check_all("tbl_cells");

    // ---- normal busy length, then side-port read colliding with a write ----
    xfer(1'b0, 1'b0, 8'h80, 1, stb, rdv);
    n = 0;
    while (busy === 1'b1 && n < 4 * BUSY) begin n++; tick(); end
    chk("busy_len", 32'(n), 32'(BUSY));
    wait_idle();
    rd_idx = 5'd0;
    tick();
    old = m_cells[0];
    xfer(1'b1, 1'b0, 8'hE5, 1, stb, rdv);
    chk("collide_old", 32'(rd_char), 32'(old));
    tick();
    chk("collide_new", 32'(rd_char), 32'hE5);
    wait_idle();

    // ---- fill line 2, clear, exact clear busy time, strobe during clear ----
    xfer(1'b0, 1'b0, 8'hC0, 1, stb, rdv);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 1'b0, 8'(8'h61 + i), 1, stb, rdv);
      wait_idle();
    end
    check_all("fill_cells");
    xfer(1'b0, 1'b0, 8'h01, 1, stb, rdv);
    n = 0;
    while (busy === 1'b1 && n < 2 * CLEAR) begin n++; tick(); end
    chk("clear_len", 32'(n), 32'(CLEAR));
    chk("clear_no_err", 32'(err_busy), 32'(0));
    check_all("clear_cells");
    wait_idle();
    xfer(1'b0, 1'b0, 8'h01, 1, stb, rdv);
    repeat (5) tick();
    xfer(1'b0, 1'b1, 8'h00, 1, stb, rdv);
    chk("clear_err_set", 32'(err_busy), 32'(1));
    wait_idle();

    // ---- reset mid-busy after a data write ----
    xfer(1'b0, 1'b0, 8'h80, 1, stb, rdv);
    wait_idle();
    xfer(1'b1, 1'b0, 8'h77, 1, stb, rdv);
    repeat (2) tick();
    xfer(1'b1, 1'b0, 8'h78, 1, stb, rdv);
    chk("pre_rst_err", 32'(err_busy), 32'(1));
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_err", 32'(err_busy), 32'(0));
    rd_idx = 5'd0; tick(); chk("mid_rst_cell0", 32'(rd_char), 32'h20);
    rd_idx = 5'd1; tick(); chk("mid_rst_cell1", 32'(rd_char), 32'h20);
    xfer(1'b0, 1'b1, 8'h00, 1, stb, rdv);
    chk("mid_rst_ac", 32'(rdv), 32'h00);

    // ---- reset coinciding with the falling edge drops the strobe ----
    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data_in = 8'h99; lcd_en = 1'b1;
    tick();
    lcd_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();
    chk("lost_strobe", 32'(wr_strobe), 32'(0));
    tick();
    chk("lost_strobe_late", 32'(wr_strobe), 32'(0));
    chk("lost_busy", 32'(busy), 32'(0));
    rd_idx = 5'd0; tick(); chk("lost_cell0", 32'(rd_char), 32'h20);

    // ---- randomized transfers against the model ----
    for (int t = 0; t < 200; t++) begin
      rs = 1'($urandom);
      rw = ($urandom_range(0, 3) == 0);
      d  = 8'($urandom);
      if (!rs && !rw) begin
        k = $urandom_range(0, 9);
        case (k)
          0, 1, 2: d = {1'b1, 1'($urandom), 2'b00, 4'($urandom)};
          3:       d = 8'h80 | 8'($urandom);
          4:       d = 8'h04 | {6'd0, 2'($urandom)};
          5:       d = 8'h10 | {4'd0, 4'($urandom)};
          6:       d = 8'h08 | {5'd0, 3'($urandom)};
          7:       ;
          8:       if ($urandom_range(0, 3) == 0) d = 8'h40 | {2'd0, 6'($urandom)};
          default: d = ($urandom_range(0, 4) == 0) ? 8'h01 : 8'h02;
        endcase
      end
      xfer(rs, rw, d, $urandom_range(1, 3), stb, rdv);
      n = $urandom_range(0, BUSY + 3);
      for (int g = 0; g < n; g++) begin
        r = $urandom_range(0, 31);
        rd_idx = 5'(r);
        tick();
        chk("gap_strobe", 32'(wr_strobe), 32'(0));
        chk("gap_busy", 32'(busy), 32'(m_busy()));
        chk("gap_rd_char", 32'(rd_char), 32'(m_cells[r]));
      end
    end
    wait_idle();
    check_all("rand_cells");
    chk("rand_err", 32'(err_busy), 32'(m_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
